bankgroup_scheduler: RTL and testbench
======================================

BANKGROUP_SCHEDULER -- requirements
Module: bankgroup_scheduler

Interface
REQ-001 The block SHALL have these parameters, one per line: name, default, meaning.
- ADDRWIDTH, 17, row address width.
- COLS, 1024, columns per row; CADDRWIDTH = clog2(COLS).
- BANKSPERGROUP, 2, banks in the group; BAWIDTH = clog2(BANKSPERGROUP); bank address width is BAWIDTH+1.
- NREQ, 2, number of requesters; IDW = max(1, clog2(NREQ)).
- TRCD, 4, minimum cycles from ACT to RD/WR.
- TRP, 4, minimum cycles from PRE to ACT.
- TRAS, 10, minimum cycles from ACT to PRE, same bank.
- TCCD, 4, minimum cycles between RD/WR commands.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk, in, 1, the single clock, rising edge.
- rst, in, 1, reset: synchronous, active-low.
- halt, in, 1, freeze.
- req_valid, in, NREQ, request valid per requester.
- req_write, in, NREQ, 1 = write, 0 = read.
- req_ba, in, NREQ*(BAWIDTH+1), bank address per requester.
- req_row, in, NREQ*ADDRWIDTH, row per requester.
- req_col, in, NREQ*CADDRWIDTH, column per requester.
- req_ready, out, NREQ, request accepted this cycle.
- commands, out, 19, one-hot command to the bank group.
- ba, out, BAWIDTH+1, bank address of the issued command.
- row, out, ADDRWIDTH, row of the issued command.
- column, out, CADDRWIDTH, column of the issued command.
- done, out, 1, pulse when a request's RD/WR issues.
- done_id, out, IDW, requester index for done.
- bank_open, out, BANKSPERGROUP, per-bank open-row flag.

Function
REQ-003 Command encoding SHALL be: commands[0] ACT, [1] PRE, [2] RD, [3] WR; all other bits always 0.
REQ-004 A command SHALL be a single-cycle pulse; in all other cycles commands SHALL be 0 (NOP).
REQ-005 ba, row and column SHALL be valid in the issue cycle and SHALL hold their last value otherwise.
REQ-006 The FSM SHALL have exactly these states: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS.
REQ-007 Arbitration in IDLE (halt=0):
- req_ready is combinational and is asserted for exactly one valid requester.
- The grant is round-robin, searching from (last granted + 1) mod NREQ.
- The granted request is latched, and the FSM moves on the next edge.
REQ-008 req_ready SHALL be 0 in every state other than IDLE.
REQ-009 On grant, the next state SHALL be chosen as follows:
- Row hit (bank open and stored row equal): CAS.
- Bank closed: ACT.
- Row miss: PRE.
REQ-010 PRE SHALL issue only once that bank's tRAS counter is 0, then go to WAIT_RP; the bank is marked closed.
REQ-011 ACT SHALL occur no earlier than TRP cycles after the PRE cycle; ACT issues, then the FSM goes to WAIT_RCD.
REQ-012 On ACT, the block SHALL:
- store the row for that bank;
- set its bank_open bit;
- load that bank's tRAS counter with TRAS.
REQ-013 RD/WR in CAS SHALL issue no earlier than TRCD cycles after ACT and no earlier than TCCD cycles after the previous RD/WR.
REQ-014 On the RD/WR issue cycle the block SHALL pulse done with done_id set, then return to IDLE.
REQ-015 All timing counters SHALL saturate at 0 and SHALL count down every cycle in which halt=0.
REQ-016 halt=1 SHALL have this effect:
- FSM, counters and latched request are frozen.
- commands = 0, req_ready = 0, done = 0.
- A command due that cycle is deferred.
REQ-017 Changes to req_* inputs after acceptance SHALL have no effect on the request in progress.

Reset
REQ-018 With rst=0 at a clock edge, the block SHALL:
- enter IDLE;
- clear commands, ba, row, column, done, done_id and bank_open;
- clear all counters;
- set the round-robin pointer so requester 0 has priority.
REQ-019 Reset SHALL abort any in-progress request with no further command issued; reset takes precedence over halt.

Verification
REQ-020 Reset, then req0 read, bank 0, row 5, col 8 -> ACT (ba=0, row=5) at cycle t; RD (column=8) at t+4; done=1 and done_id=0 at t+4.
REQ-021 Immediately after, req0 read bank 0 row 5 col 16 -> no ACT; RD at previous RD+4.
REQ-022 Then req1 write bank 0 row 9 -> PRE at or after first ACT+10; ACT row 9 at PRE+4; WR at ACT+4; done_id=1.
REQ-023 Both req_valid held high, all row hits -> grants alternate 0,1,0,1 and no requester is granted twice in a row.
REQ-024 halt=1 for 3 cycles during WAIT_RCD -> RD at ACT+7; commands=0 and req_ready=0 throughout the halt.
REQ-025 rst=0 for one cycle during WAIT_RP -> next cycle: IDLE, bank_open=0, commands=0, and no ACT issued.

Source files
------------

// File: rtl/bankgroup_scheduler.sv
// Single-bank-group DRAM command scheduler: round-robin request arbitration,
// open-row tracking per bank, and ACT/PRE/RD/WR sequencing under tRCD/tRP/tRAS/tCCD.
module bankgroup_scheduler #(
    parameter int ADDRWIDTH     = 17,
    parameter int COLS          = 1024,
    parameter int BANKSPERGROUP = 2,
    parameter int NREQ          = 2,
    parameter int TRCD          = 4,
    parameter int TRP           = 4,
    parameter int TRAS          = 10,
    parameter int TCCD          = 4,
    localparam int CADDRWIDTH   = $clog2(COLS),
    localparam int BAWIDTH      = $clog2(BANKSPERGROUP),
    localparam int IDW          = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              halt,
    input  logic [NREQ-1:0]                   req_valid,
    input  logic [NREQ-1:0]                   req_write,
    input  logic [NREQ*(BAWIDTH+1)-1:0]       req_ba,
    input  logic [NREQ*ADDRWIDTH-1:0]         req_row,
    input  logic [NREQ*CADDRWIDTH-1:0]        req_col,
    output logic [NREQ-1:0]                   req_ready,
    output logic [18:0]                       commands,
    output logic [BAWIDTH:0]                  ba,
    output logic [ADDRWIDTH-1:0]              row,
    output logic [CADDRWIDTH-1:0]             column,
    output logic                              done,
    output logic [IDW-1:0]                    done_id,
    output logic [BANKSPERGROUP-1:0]          bank_open
);

    localparam int BAW  = BAWIDTH + 1;
    localparam int BIW  = (BAWIDTH > 0) ? BAWIDTH : 1;
    localparam int TM1  = (TRAS > TRP) ? TRAS : TRP;
    localparam int TM2  = (TRCD > TCCD) ? TRCD : TCCD;
    localparam int TMAX = (TM1 > TM2) ? TM1 : TM2;
    localparam int CNTW = $clog2(TMAX + 1);

    localparam int C_ACT = 0;
    localparam int C_PRE = 1;
    localparam int C_RD  = 2;
    localparam int C_WR  = 3;

    typedef enum logic [2:0] {IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, CAS} state_t;

    state_t                 r_state, w_next;
    logic [IDW-1:0]         r_last, r_id;
    logic                   r_wr;
    logic [BAW-1:0]         r_rba;
    logic [ADDRWIDTH-1:0]   r_rrow;
    logic [CADDRWIDTH-1:0]  r_rcol;
    logic [BANKSPERGROUP-1:0] r_open;
    logic [ADDRWIDTH-1:0]   r_open_row [BANKSPERGROUP];
    logic [CNTW-1:0]        r_tras [BANKSPERGROUP];
    logic [CNTW-1:0]        r_rp, r_rcd, r_ccd;
    logic [BAW-1:0]         r_ba;
    logic [ADDRWIDTH-1:0]   r_row;
    logic [CADDRWIDTH-1:0]  r_col;

    logic                   w_gnt_found, w_grant, w_hit;
    logic [IDW-1:0]         w_gnt_id;
    logic [BAW-1:0]         w_sel_ba;
    logic [ADDRWIDTH-1:0]   w_sel_row;
    logic [CADDRWIDTH-1:0]  w_sel_col;
    logic [BIW-1:0]         w_sel_bank, w_bank;
    logic [3:0]             w_cmd;

    function automatic logic [CNTW-1:0] sat_dec(input logic [CNTW-1:0] v);
        return (v == '0) ? v : v - CNTW'(1);
    endfunction

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] last, input int k);
        int i;
        i = (int'(last) + 1 + k) % NREQ;
        return IDW'(i);
    endfunction

    // Round-robin search starting just after the last granted requester
    always_comb begin
        w_gnt_found = 1'b0;
        w_gnt_id    = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_gnt_found && req_valid[rr_index(r_last, k)]) begin
                w_gnt_found = 1'b1;
                w_gnt_id    = rr_index(r_last, k);
            end
        end
    end

    assign w_sel_ba   = req_ba[int'(w_gnt_id)*BAW +: BAW];
    assign w_sel_row  = req_row[int'(w_gnt_id)*ADDRWIDTH +: ADDRWIDTH];
    assign w_sel_col  = req_col[int'(w_gnt_id)*CADDRWIDTH +: CADDRWIDTH];
    assign w_sel_bank = w_sel_ba[BIW-1:0];
    assign w_bank     = r_rba[BIW-1:0];
    assign w_hit      = r_open[w_sel_bank] && (r_open_row[w_sel_bank] == w_sel_row);
    assign w_grant    = (r_state == IDLE) && !halt && rst && w_gnt_found;

    always_comb begin
        w_next = r_state;
        w_cmd  = '0;
        case (r_state)
            IDLE: begin
                if (w_grant) begin
                    if (w_hit)                   w_next = CAS;
                    else if (r_open[w_sel_bank]) w_next = PRE;
                    else                         w_next = ACT;
                end
            end
            PRE: begin
                if (!halt && r_tras[w_bank] == '0) begin
                    w_cmd[C_PRE] = 1'b1;
                    w_next       = WAIT_RP;
                end
            end
            WAIT_RP: begin
                if (!halt && r_rp <= CNTW'(1)) w_next = ACT;
            end
            ACT: begin
                if (!halt && r_rp == '0) begin
                    w_cmd[C_ACT] = 1'b1;
                    w_next       = WAIT_RCD;
                end
            end
            WAIT_RCD: begin
                if (!halt && r_rcd <= CNTW'(1)) w_next = CAS;
            end
            CAS: begin
                if (!halt && r_rcd == '0 && r_ccd == '0) begin
                    w_cmd[r_wr ? C_WR : C_RD] = 1'b1;
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
        if (!rst) begin
            w_cmd  = '0;
            w_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_last  <= IDW'(NREQ - 1);
            r_id    <= '0;
            r_open  <= '0;
            r_rp    <= '0;
            r_rcd   <= '0;
            r_ccd   <= '0;
            for (int b = 0; b < BANKSPERGROUP; b++) r_tras[b] <= '0;
            r_ba    <= '0;
            r_row   <= '0;
            r_col   <= '0;
        end else if (!halt) begin
            r_state <= w_next;
            r_rp    <= sat_dec(r_rp);
            r_rcd   <= sat_dec(r_rcd);
            r_ccd   <= sat_dec(r_ccd);
            for (int b = 0; b < BANKSPERGROUP; b++) r_tras[b] <= sat_dec(r_tras[b]);
            if (w_grant) begin
                r_last <= w_gnt_id;
                r_id   <= w_gnt_id;
            end
            // Loads are one less than the parameter: the issuing edge counts as the first cycle
            if (w_cmd[C_PRE]) begin
                r_open[w_bank] <= 1'b0;
                r_rp           <= CNTW'(TRP - 1);
            end
            if (w_cmd[C_ACT]) begin
                r_open[w_bank] <= 1'b1;
                r_tras[w_bank] <= CNTW'(TRAS - 1);
                r_rcd          <= CNTW'(TRCD - 1);
            end
            if (w_cmd[C_RD] || w_cmd[C_WR]) r_ccd <= CNTW'(TCCD - 1);
            if (|w_cmd) begin
                r_ba  <= r_rba;
                r_row <= r_rrow;
                r_col <= r_rcol;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_grant) begin
            r_wr   <= req_write[w_gnt_id];
            r_rba  <= w_sel_ba;
            r_rrow <= w_sel_row;
            r_rcol <= w_sel_col;
        end
        if (w_cmd[C_ACT]) r_open_row[w_bank] <= r_rrow;
    end

    assign req_ready = w_grant ? (NREQ'(1) << w_gnt_id) : '0;
    assign commands  = {15'b0, w_cmd};
    assign ba        = (|w_cmd) ? r_rba  : r_ba;
    assign row       = (|w_cmd) ? r_rrow : r_row;
    assign column    = (|w_cmd) ? r_rcol : r_col;
    assign done      = w_cmd[C_RD] | w_cmd[C_WR];
    assign done_id   = r_id;
    assign bank_open = r_open;

endmodule

// File: tb/tb_bankgroup_scheduler.sv
// Directed bench for bankgroup_scheduler: open/closed/missed rows, arbitration,
// halt and mid-sequence reset, with hand-derived command timing.
module tb_bankgroup_scheduler;
    localparam int AW  = 17;
    localparam int CW  = 10;
    localparam int BAW = 2;
    localparam int NR  = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              halt = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR-1:0]     req_write = '0;
    logic [NR*BAW-1:0] req_ba = '0;
    logic [NR*AW-1:0]  req_row = '0;
    logic [NR*CW-1:0]  req_col = '0;
    logic [NR-1:0]     req_ready;
    logic [18:0]       commands;
    logic [BAW-1:0]    ba;
    logic [AW-1:0]     row;
    logic [CW-1:0]     column;
    logic              done;
    logic [0:0]        done_id;
    logic [1:0]        bank_open;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int t_act1, t_rd1, t_rd2;

    bankgroup_scheduler dut (
        .clk(clk), .rst(rst), .halt(halt),
        .req_valid(req_valid), .req_write(req_write), .req_ba(req_ba),
        .req_row(req_row), .req_col(req_col), .req_ready(req_ready),
        .commands(commands), .ba(ba), .row(row), .column(column),
        .done(done), .done_id(done_id), .bank_open(bank_open)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    task automatic set_req(input int id, input logic wr, input logic [1:0] b,
                           input logic [16:0] r, input logic [9:0] c);
        req_write[id]           = wr;
        req_ba[id*BAW +: BAW]   = b;
        req_row[id*AW +: AW]    = r;
        req_col[id*CW +: CW]    = c;
        req_valid[id]           = 1'b1;
    endtask

    // Present a request, wait for its grant, then drop it and scramble its fields
    task automatic issue_req(input int id, input logic wr, input logic [1:0] b,
                             input logic [16:0] r, input logic [9:0] c, output int gcyc);
        set_req(id, wr, b, r, c);
        #1;
        gcyc = -1;
        for (int k = 0; k < 60; k++) begin
            if (req_ready != '0) begin gcyc = cyc; break; end
            @(negedge clk); #1;
        end
        total++;
        if (gcyc < 0 || req_ready !== NR'(1 << id)) begin
            bad++; $display("FAIL grant_req%0d got=%b want=%b", id, req_ready, NR'(1 << id));
        end
        if (gcyc >= 0) begin
            @(posedge clk); #1;
            req_valid[id]         = 1'b0;
            req_write[id]         = ~wr;
            req_ba[id*BAW +: BAW] = ~b;
            req_row[id*AW +: AW]  = '1;
            req_col[id*CW +: CW]  = '1;
        end
    endtask

    task automatic wait_cmd(output int at, output logic [18:0] cmd);
        at = -1;
        cmd = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk); #1;
            if (commands != '0) begin at = cyc; cmd = commands; break; end
        end
        if (at < 0) begin
            total++; bad++; $display("FAIL cmd_wait got=none want=command");
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        total++; if (commands !== 19'd0) begin bad++; $display("FAIL rst_commands got=%0h want=0", commands); end
        total++; if (bank_open !== 2'b00) begin bad++; $display("FAIL rst_bank_open got=%b want=00", bank_open); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
        total++; if (done_id !== 1'b0) begin bad++; $display("FAIL rst_done_id got=%b want=0", done_id); end
        total++; if (ba !== 2'd0 || row !== 17'd0 || column !== 10'd0) begin
            bad++; $display("FAIL rst_addr got=%0h/%0h/%0h want=0/0/0", ba, row, column);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL rst_ready got=%b want=00", req_ready); end
    endtask

    task automatic test_closed_bank();
        int g, t, t2;
        logic [18:0] c;
        issue_req(0, 1'b0, 2'd0, 17'd5, 10'd8, g);
        wait_cmd(t, c);
        t_act1 = t;
        total++; if (c !== 19'd1) begin bad++; $display("FAIL act1_cmd got=%0h want=1", c); end
        total++; if (ba !== 2'd0 || row !== 17'd5) begin bad++; $display("FAIL act1_addr got=%0h/%0h want=0/5", ba, row); end
        wait_cmd(t2, c);
        t_rd1 = t2;
        total++; if (c !== 19'd4) begin bad++; $display("FAIL rd1_cmd got=%0h want=4", c); end
        total++; if (t2 !== t + 4) begin bad++; $display("FAIL rd1_time got=%0d want=%0d", t2, t + 4); end
        total++; if (column !== 10'd8) begin bad++; $display("FAIL rd1_col got=%0d want=8", column); end
        total++; if (done !== 1'b1 || done_id !== 1'b0) begin bad++; $display("FAIL rd1_done got=%b/%b want=1/0", done, done_id); end
        total++; if (bank_open !== 2'b01) begin bad++; $display("FAIL rd1_bank_open got=%b want=01", bank_open); end
    endtask

    task automatic test_row_hit();
        int g, t;
        logic [18:0] c;
        issue_req(0, 1'b0, 2'd0, 17'd5, 10'd16, g);
        wait_cmd(t, c);
        t_rd2 = t;
        total++; if (c !== 19'd4) begin bad++; $display("FAIL hit_cmd got=%0h want=4", c); end
        total++; if (t !== t_rd1 + 4) begin bad++; $display("FAIL hit_time got=%0d want=%0d", t, t_rd1 + 4); end
        total++; if (column !== 10'd16) begin bad++; $display("FAIL hit_col got=%0d want=16", column); end
    endtask

    task automatic test_row_miss();
        int g, p, a, w;
        logic [18:0] c;
        issue_req(1, 1'b1, 2'd0, 17'd9, 10'd3, g);
        wait_cmd(p, c);
        total++; if (c !== 19'd2) begin bad++; $display("FAIL miss_pre_cmd got=%0h want=2", c); end
        total++; if (p < t_act1 + 10) begin bad++; $display("FAIL miss_pre_tras got=%0d want>=%0d", p, t_act1 + 10); end
        total++; if (ba !== 2'd0) begin bad++; $display("FAIL miss_pre_ba got=%0d want=0", ba); end
        wait_cmd(a, c);
        total++; if (c !== 19'd1) begin bad++; $display("FAIL miss_act_cmd got=%0h want=1", c); end
        total++; if (a !== p + 4) begin bad++; $display("FAIL miss_act_time got=%0d want=%0d", a, p + 4); end
        total++; if (row !== 17'd9) begin bad++; $display("FAIL miss_act_row got=%0d want=9", row); end
        wait_cmd(w, c);
        total++; if (c !== 19'd8) begin bad++; $display("FAIL miss_wr_cmd got=%0h want=8", c); end
        total++; if (w !== a + 4) begin bad++; $display("FAIL miss_wr_time got=%0d want=%0d", w, a + 4); end
        total++; if (column !== 10'd3) begin bad++; $display("FAIL miss_wr_col got=%0d want=3", column); end
        total++; if (done !== 1'b1 || done_id !== 1'b1) begin bad++; $display("FAIL miss_wr_done got=%b/%b want=1/1", done, done_id); end
    endtask

    task automatic test_back_to_back();
        int gid [4];
        int exp_gid [4];
        int n, nrow, t;
        logic [18:0] c;
        exp_gid = '{0, 1, 0, 1};
        n = 0;
        nrow = 0;
        set_req(0, 1'b0, 2'd0, 17'd9, 10'd1);
        set_req(1, 1'b0, 2'd0, 17'd9, 10'd2);
        for (int k = 0; k < 100 && n < 4; k++) begin
            @(negedge clk); #1;
            if (commands[0] || commands[1]) nrow++;
            if (req_ready != '0) begin
                gid[n] = (req_ready == 2'b01) ? 0 : (req_ready == 2'b10) ? 1 : 9;
                n++;
            end
        end
        total++; if (n !== 4) begin bad++; $display("FAIL rr_count got=%0d want=4", n); end
        for (int i = 0; i < 4; i++) begin
            if (i < n) begin
                total++;
                if (gid[i] !== exp_gid[i]) begin bad++; $display("FAIL rr_grant%0d got=%0d want=%0d", i, gid[i], exp_gid[i]); end
            end
        end
        total++; if (nrow !== 0) begin bad++; $display("FAIL rr_no_act_pre got=%0d want=0", nrow); end
        @(posedge clk); #1;
        req_valid = '0;
        wait_cmd(t, c);
        total++; if (c !== 19'd4 || done_id !== 1'b1) begin bad++; $display("FAIL rr_last_done got=%0h/%b want=4/1", c, done_id); end
    endtask

    task automatic test_halt();
        int g, a, r;
        logic [18:0] c;
        set_req(0, 1'b0, 2'd1, 17'd7, 10'd5);
        halt = 1'b1;
        #1;
        total++; if (req_ready !== 2'b00) begin bad++; $display("FAIL halt_idle_ready got=%b want=00", req_ready); end
        @(negedge clk); #1;
        total++; if (commands !== 19'd0) begin bad++; $display("FAIL halt_idle_cmd got=%0h want=0", commands); end
        halt = 1'b0;
        issue_req(0, 1'b0, 2'd1, 17'd7, 10'd5, g);
        wait_cmd(a, c);
        total++; if (c !== 19'd1 || ba !== 2'd1 || row !== 17'd7) begin
            bad++; $display("FAIL halt_act got=%0h/%0d/%0d want=1/1/7", c, ba, row);
        end
        @(posedge clk); #1;
        halt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            total++; if (commands !== 19'd0 || req_ready !== 2'b00) begin
                bad++; $display("FAIL halt_cycle%0d got=%0h/%b want=0/00", i, commands, req_ready);
            end
            @(posedge clk); #1;
        end
        halt = 1'b0;
        wait_cmd(r, c);
        total++; if (c !== 19'd4) begin bad++; $display("FAIL halt_rd_cmd got=%0h want=4", c); end
        total++; if (r !== a + 7) begin bad++; $display("FAIL halt_rd_time got=%0d want=%0d", r, a + 7); end
        total++; if (column !== 10'd5) begin bad++; $display("FAIL halt_rd_col got=%0d want=5", column); end
    endtask

    task automatic test_reset_wait_rp();
        int g, p, ncmd;
        logic [18:0] c;
        issue_req(0, 1'b0, 2'd1, 17'd11, 10'd1, g);
        wait_cmd(p, c);
        total++; if (c !== 19'd2) begin bad++; $display("FAIL rwr_pre_cmd got=%0h want=2", c); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk); #1;
        total++; if (commands !== 19'd0) begin bad++; $display("FAIL rwr_rst_cmd got=%0h want=0", commands); end
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        total++; if (bank_open !== 2'b00) begin bad++; $display("FAIL rwr_bank_open got=%b want=00", bank_open); end
        total++; if (commands !== 19'd0) begin bad++; $display("FAIL rwr_cmd got=%0h want=0", commands); end
        ncmd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); #1;
            if (commands != '0) ncmd++;
        end
        total++; if (ncmd !== 0) begin bad++; $display("FAIL rwr_no_act got=%0d want=0", ncmd); end
        set_req(0, 1'b0, 2'd0, 17'd1, 10'd0);
        set_req(1, 1'b0, 2'd0, 17'd1, 10'd0);
        #1;
        total++; if (req_ready !== 2'b01) begin bad++; $display("FAIL rwr_priority got=%b want=01", req_ready); end
        req_valid = '0;
    endtask

    initial begin
        test_reset();
        test_closed_bank();
        test_row_hit();
        test_row_miss();
        test_back_to_back();
        test_halt();
        test_reset_wait_rp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
